// File: rtl/vga_tinyvga_out.sv
// vga_tinyvga_out: VGA timing generator and Tiny VGA PMOD output stage.
// A clock divider produces a pixel strobe, the h/v counters walk the raster,
// and colour plus syncs are registered into the Tiny VGA pin order on uo_out.
module vga_tinyvga_out #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [5:0] rgb_in,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       px_active,
  output logic       pix_stb,
  output logic       frame_start,
  output logic [7:0] uo_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // 11-bit bounds so a 1024-wide raster still compares correctly
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // syncs inactive, all colour bits dark
  localparam logic [7:0] UO_IDLE = {~SYNC_POL, 3'b000, ~SYNC_POL, 3'b000};

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_tinyvga_out: CLK_DIV must be >= 1");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_tinyvga_out: H_TOTAL and V_TOTAL must fit 10-bit counters");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt;
  logic             hs_on;
  logic             vs_on;
  logic [5:0]       colour;

  assign pix_stb   = ena && (div_cnt == DIV_LAST);
  assign px_active = ({1'b0, px_x} < H_ACT) && ({1'b0, px_y} < V_ACT);
  assign hs_on     = ({1'b0, px_x} >= HS_START) && ({1'b0, px_x} < HS_END);
  assign vs_on     = ({1'b0, px_y} >= VS_START) && ({1'b0, px_y} < VS_END);
  assign colour    = px_active ? rgb_in : 6'b000000;

  // Divider, raster counters and the output register for the pixel being left
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      px_x        <= '0;
      px_y        <= '0;
      frame_start <= 1'b0;
      uo_out      <= UO_IDLE;
    end else if (!ena) begin
      div_cnt     <= '0;
      px_x        <= '0;
      px_y        <= '0;
      frame_start <= 1'b0;
      uo_out      <= UO_IDLE;
    end else begin
      frame_start <= 1'b0;
      if (pix_stb) begin
        div_cnt     <= '0;
        frame_start <= (px_x == 10'd0) && (px_y == 10'd0);
        // rgb_in = {R1,R0,G1,G0,B1,B0} -> {HS,B0,G0,R0,VS,B1,G1,R1}
        uo_out      <= {hs_on ? SYNC_POL : ~SYNC_POL, colour[0], colour[2], colour[4],
                        vs_on ? SYNC_POL : ~SYNC_POL, colour[1], colour[3], colour[5]};
        if (px_x == H_LAST) begin
          px_x <= '0;
          px_y <= (px_y == V_LAST) ? 10'd0 : px_y + 10'd1;
        end else begin
          px_x <= px_x + 10'd1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_tinyvga_out.sv
// tb_vga_tinyvga_out: two instances share stimulus. Instance a uses a shrunken
// 32x15 raster with CLK_DIV=4 and active-low syncs so whole frames fit in a
// short run; instance b uses the full 800x525 raster with CLK_DIV=1 and
// active-high syncs. Expectations come from the number of enabled clocks since
// the last restart, turned into a pixel index with plain arithmetic.
module tb_vga_tinyvga_out;

  // index 0 = instance a, index 1 = instance b
  localparam int P_D  [2] = '{4, 1};
  localparam int P_HA [2] = '{16, 640};
  localparam int P_HF [2] = '{4, 16};
  localparam int P_HS [2] = '{6, 96};
  localparam int P_HB [2] = '{6, 48};
  localparam int P_VA [2] = '{8, 480};
  localparam int P_VF [2] = '{2, 10};
  localparam int P_VS [2] = '{2, 2};
  localparam int P_VB [2] = '{3, 33};
  localparam bit P_POL[2] = '{1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [5:0] rgb_in = 6'd0;

  logic [9:0] a_px_x, a_px_y, b_px_x, b_px_y;
  logic       a_active, a_stb, a_fs, b_active, b_stb, b_fs;
  logic [7:0] a_uo, b_uo;

  int passed = 0;
  int total  = 0;

  // model state: enabled clocks since restart, rgb captured at the last strobe
  int         n   [2];
  logic [5:0] lrgb[2];

  always #5 clk = ~clk;

  vga_tinyvga_out #(
    .CLK_DIV(4), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u_a (
    .clk(clk), .rst(rst), .ena(ena), .rgb_in(rgb_in),
    .px_x(a_px_x), .px_y(a_px_y), .px_active(a_active), .pix_stb(a_stb),
    .frame_start(a_fs), .uo_out(a_uo)
  );

  vga_tinyvga_out #(
    .CLK_DIV(1), .SYNC_POL(1'b1)
  ) u_b (
    .clk(clk), .rst(rst), .ena(ena), .rgb_in(rgb_in),
    .px_x(b_px_x), .px_y(b_px_y), .px_active(b_active), .pix_stb(b_stb),
    .frame_start(b_fs), .uo_out(b_uo)
  );

  function automatic int h_tot(int b);
    return P_HA[b] + P_HF[b] + P_HS[b] + P_HB[b];
  endfunction

  function automatic int f_tot(int b);
    return h_tot(b) * (P_VA[b] + P_VF[b] + P_VS[b] + P_VB[b]);
  endfunction

  function automatic int exp_x(int b, int cnt);
    return ((cnt / P_D[b]) % f_tot(b)) % h_tot(b);
  endfunction

  function automatic int exp_y(int b, int cnt);
    return ((cnt / P_D[b]) % f_tot(b)) / h_tot(b);
  endfunction

  function automatic logic [7:0] exp_uo(int b, int cnt, logic [5:0] c_in);
    int q, x, y;
    logic de, hs, vs;
    logic [5:0] c;
    bit pol;
    pol = P_POL[b];
    if (cnt < P_D[b]) return {~pol, 3'b000, ~pol, 3'b000};
    q  = (cnt / P_D[b] - 1) % f_tot(b);
    x  = q % h_tot(b);
    y  = q / h_tot(b);
    de = (x < P_HA[b]) && (y < P_VA[b]);
    hs = (x >= P_HA[b] + P_HF[b] && x < P_HA[b] + P_HF[b] + P_HS[b]) ? pol : ~pol;
    vs = (y >= P_VA[b] + P_VF[b] && y < P_VA[b] + P_VF[b] + P_VS[b]) ? pol : ~pol;
    c  = de ? c_in : 6'd0;
    return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endfunction

  function automatic logic exp_fs(int b, int cnt);
    return (cnt >= P_D[b]) && (cnt % P_D[b] == 0) && ((cnt / P_D[b] - 1) % f_tot(b) == 0);
  endfunction

  // one clock with the given inputs; returns at the following negedge
  task automatic tick(input logic e, input logic [5:0] r);
    ena    = e;
    rgb_in = r;
    @(posedge clk);
    for (int b = 0; b < 2; b++) begin
      if (!e) n[b] = 0;
      else begin
        if (n[b] % P_D[b] == P_D[b] - 1) lrgb[b] = r;
        n[b]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    n[0] = 0;
    n[1] = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; rgb_in = 6'h3F;
    repeat (3) @(negedge clk);
    total++; if (a_uo !== 8'h88) $display("FAIL reset_a_uo got %h want 88", a_uo); else passed++;
    total++; if (b_uo !== 8'h00) $display("FAIL reset_b_uo got %h want 00", b_uo); else passed++;
    total++; if (a_px_x !== 10'd0 || a_px_y !== 10'd0) $display("FAIL reset_a_px got %0d,%0d want 0,0", a_px_x, a_px_y); else passed++;
    total++; if (a_fs !== 1'b0 || b_fs !== 1'b0) $display("FAIL reset_fs got %b%b want 00", a_fs, b_fs); else passed++;
    rst = 1'b0; n[0] = 0; n[1] = 0;
  endtask

  task automatic test_pin_mapping();
    total++; if (a_stb !== 1'b0) $display("FAIL pin_a_stb0 got %b want 0", a_stb); else passed++;
    tick(1'b1, 6'b10_01_11);
    total++; if (b_uo !== 8'h65) $display("FAIL pin_b_uo got %h want 65", b_uo); else passed++;
    total++; if (b_fs !== 1'b1) $display("FAIL pin_b_fs got %b want 1", b_fs); else passed++;
    tick(1'b1, 6'b10_01_11);
    tick(1'b1, 6'b10_01_11);
    total++; if (a_stb !== 1'b1) $display("FAIL pin_a_stb3 got %b want 1", a_stb); else passed++;
    total++; if (a_uo !== 8'h88) $display("FAIL pin_a_pre got %h want 88", a_uo); else passed++;
    tick(1'b1, 6'b10_01_11);
    total++; if (a_uo !== 8'hED) $display("FAIL pin_a_uo got %h want ED", a_uo); else passed++;
    total++; if (a_fs !== 1'b1) $display("FAIL pin_a_fs got %b want 1", a_fs); else passed++;
    total++; if (a_px_x !== 10'd1) $display("FAIL pin_a_px_x got %0d want 1", a_px_x); else passed++;
  endtask

  task automatic test_line_timing();
    int a_hs_low, a_col, b_hs_hi, b_stb_lo, b_wrap;
    do_reset();
    a_hs_low = 0; a_col = 0; b_hs_hi = 0; b_stb_lo = 0; b_wrap = -1;
    for (int i = 1; i <= 1600; i++) begin
      tick(1'b1, 6'h3F);
      if (n[0] >= 4 && n[0] < 4 + 32 * 4) begin
        if (a_uo[7] == 1'b0) a_hs_low++;
        if ((a_uo & 8'h77) != 8'h00) a_col++;
      end
      if (n[1] <= 800 && b_uo[7] == 1'b1) b_hs_hi++;
      if (b_stb !== 1'b1) b_stb_lo++;
      if (b_wrap < 0 && b_px_x == 10'd0) b_wrap = n[1];
    end
    total++; if (a_hs_low != 24) $display("FAIL line_a_hs_low got %0d want 24", a_hs_low); else passed++;
    total++; if (a_col != 64) $display("FAIL line_a_colour got %0d want 64", a_col); else passed++;
    total++; if (b_hs_hi != 96) $display("FAIL line_b_hs_high got %0d want 96", b_hs_hi); else passed++;
    total++; if (b_stb_lo != 0) $display("FAIL line_b_stb_low got %0d want 0", b_stb_lo); else passed++;
    total++; if (b_wrap != 800) $display("FAIL line_b_period got %0d want 800", b_wrap); else passed++;
  endtask

  task automatic test_frame_timing();
    int fs0, fs1, vs_low;
    do_reset();
    fs0 = -1; fs1 = -1; vs_low = 0;
    for (int i = 1; i <= 2 * 1920 + 8; i++) begin
      tick(1'b1, 6'($urandom));
      if (a_fs === 1'b1) begin
        if (fs0 < 0) fs0 = n[0];
        else if (fs1 < 0) fs1 = n[0];
      end
      if (n[0] >= 4 && n[0] < 4 + 1920 && a_uo[3] == 1'b0) vs_low++;
    end
    total++; if (fs0 != 4) $display("FAIL frame_first_fs got %0d want 4", fs0); else passed++;
    total++; if (fs1 - fs0 != 1920) $display("FAIL frame_period got %0d want 1920", fs1 - fs0); else passed++;
    total++; if (vs_low != 256) $display("FAIL frame_vs_low got %0d want 256", vs_low); else passed++;
  endtask

  task automatic test_ena_drop();
    int budget;
    do_reset();
    budget = 0;
    while (!(a_px_x == 10'd10 && a_px_y == 10'd5) && budget < 2000) begin
      tick(1'b1, 6'($urandom));
      budget++;
    end
    total++; if (budget >= 2000) $display("FAIL ena_reach_pos got timeout want px 10,5"); else passed++;
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 6'h3F);
      total++; if (a_px_x !== 10'd0 || a_px_y !== 10'd0) $display("FAIL ena_off_px got %0d,%0d want 0,0", a_px_x, a_px_y); else passed++;
      total++; if (a_uo !== 8'h88 || b_uo !== 8'h00) $display("FAIL ena_off_uo got %h/%h want 88/00", a_uo, b_uo); else passed++;
      total++; if (a_fs !== 1'b0 || a_stb !== 1'b0) $display("FAIL ena_off_fs_stb got %b%b want 00", a_fs, a_stb); else passed++;
    end
    for (int k = 1; k <= 4; k++) begin
      tick(1'b1, 6'h15);
      total++;
      if (a_fs !== (k == 4)) $display("FAIL ena_restart_fs clk %0d got %b want %b", k, a_fs, (k == 4)); else passed++;
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 237; i++) tick(1'b1, 6'($urandom));
    #2 rst = 1'b1;
    #1;
    total++; if (a_uo !== 8'h88 || b_uo !== 8'h00) $display("FAIL midrst_uo got %h/%h want 88/00", a_uo, b_uo); else passed++;
    total++; if (a_px_x !== 10'd0 || a_px_y !== 10'd0 || b_px_x !== 10'd0) $display("FAIL midrst_px got %0d,%0d,%0d want 0", a_px_x, a_px_y, b_px_x); else passed++;
    @(negedge clk);
    rst = 1'b0; n[0] = 0; n[1] = 0;
    for (int k = 1; k <= 4; k++) tick(1'b1, 6'b10_01_11);
    total++; if (a_fs !== 1'b1 || a_uo !== 8'hED) $display("FAIL midrst_restart got fs=%b uo=%h want 1/ED", a_fs, a_uo); else passed++;
  endtask

  task automatic test_random();
    logic e;
    do_reset();
    for (int i = 0; i < 4500; i++) begin
      e = ($urandom_range(0, 1499) != 0);
      tick(e, 6'($urandom));
      for (int b = 0; b < 2; b++) begin
        logic [7:0] uo;
        logic [9:0] x, y;
        logic fs, stb, act;
        uo  = b ? b_uo : a_uo;
        x   = b ? b_px_x : a_px_x;
        y   = b ? b_px_y : a_px_y;
        fs  = b ? b_fs : a_fs;
        stb = b ? b_stb : a_stb;
        act = b ? b_active : a_active;
        total++; if (uo !== exp_uo(b, n[b], lrgb[b])) $display("FAIL rand_uo inst %0d n %0d got %h want %h", b, n[b], uo, exp_uo(b, n[b], lrgb[b])); else passed++;
        total++; if (int'(x) != exp_x(b, n[b]) || int'(y) != exp_y(b, n[b])) $display("FAIL rand_px inst %0d n %0d got %0d,%0d want %0d,%0d", b, n[b], x, y, exp_x(b, n[b]), exp_y(b, n[b])); else passed++;
        total++; if (fs !== exp_fs(b, n[b])) $display("FAIL rand_fs inst %0d n %0d got %b want %b", b, n[b], fs, exp_fs(b, n[b])); else passed++;
        total++; if (stb !== (e && (n[b] % P_D[b] == P_D[b] - 1))) $display("FAIL rand_stb inst %0d n %0d got %b", b, n[b], stb); else passed++;
        total++; if (act !== (exp_x(b, n[b]) < P_HA[b] && exp_y(b, n[b]) < P_VA[b])) $display("FAIL rand_active inst %0d n %0d got %b", b, n[b], act); else passed++;
      end
    end
  endtask

  initial begin
    n[0] = 0; n[1] = 0; lrgb[0] = 6'd0; lrgb[1] = 6'd0;
    test_reset();
    test_pin_mapping();
    test_line_timing();
    test_frame_timing();
    test_ena_drop();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
